// File: rtl/regfile_wb_sink.sv
// Architectural register file with writeback sink, two combinational read ports
// and a per-register pending scoreboard. Optional forwarding: REGFILE_WB_BYPASS_EN.
module regfile_wb_sink #(
  parameter int IALU_WORD_WIDTH = 16,
  parameter int REG_IDX_WIDTH   = 4
) (
  input  logic                       clock,
  input  logic                       reset,
  input  logic                       in_act_write_res_to_reg,
  input  logic [IALU_WORD_WIDTH-1:0] in_res,
  input  logic [REG_IDX_WIDTH-1:0]   in_res_reg_idx,
  input  logic                       in_issue_valid,
  input  logic [REG_IDX_WIDTH-1:0]   in_issue_dst_idx,
  input  logic [REG_IDX_WIDTH-1:0]   in_rd_idx_a,
  input  logic [REG_IDX_WIDTH-1:0]   in_rd_idx_b,
  output logic [IALU_WORD_WIDTH-1:0] out_rd_data_a,
  output logic [IALU_WORD_WIDTH-1:0] out_rd_data_b,
  output logic                       out_pending_a,
  output logic                       out_pending_b,
  output logic                       out_stall
);

  localparam int NUM_REGS = 2 ** REG_IDX_WIDTH;

  logic [IALU_WORD_WIDTH-1:0] regs [NUM_REGS];
  logic [NUM_REGS-1:0]        pending;
  logic [NUM_REGS-1:0]        pending_next;

  // Clear first, then set: an issue in the same cycle is younger than the commit.
  always_comb begin
    pending_next = pending;
    if (in_act_write_res_to_reg)
      pending_next[in_res_reg_idx] = 1'b0;
    if (in_issue_valid)
      pending_next[in_issue_dst_idx] = 1'b1;
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      for (int i = 0; i < NUM_REGS; i++)
        regs[i] <= '0;
      pending <= '0;
    end else begin
      if (in_act_write_res_to_reg)
        regs[in_res_reg_idx] <= in_res;
      pending <= pending_next;
    end
  end

  always_comb begin
    out_rd_data_a = regs[in_rd_idx_a];
    out_rd_data_b = regs[in_rd_idx_b];
    out_pending_a = pending[in_rd_idx_a];
    out_pending_b = pending[in_rd_idx_b];
`ifdef REGFILE_WB_BYPASS_EN
    // Forward the committing result; only a same-cycle re-issue keeps it pending.
    if (in_act_write_res_to_reg && (in_rd_idx_a == in_res_reg_idx)) begin
      out_rd_data_a = in_res;
      out_pending_a = in_issue_valid && (in_issue_dst_idx == in_rd_idx_a);
    end
    if (in_act_write_res_to_reg && (in_rd_idx_b == in_res_reg_idx)) begin
      out_rd_data_b = in_res;
      out_pending_b = in_issue_valid && (in_issue_dst_idx == in_rd_idx_b);
    end
`endif
    out_stall = out_pending_a | out_pending_b;
  end

endmodule

// File: tb/tb_regfile_wb_sink.sv
// Table-driven bench for regfile_wb_sink; expected values pass through a scoreboard queue.
module tb_regfile_wb_sink;

`ifdef REGFILE_WB_BYPASS_EN
  localparam bit BYP = 1'b1;
`else
  localparam bit BYP = 1'b0;
`endif

  typedef struct {
    logic        rst;
    logic        wr;
    logic [15:0] res;
    logic [3:0]  widx;
    logic        iss;
    logic [3:0]  iidx;
    logic [3:0]  ra;
    logic [3:0]  rb;
    logic        chk;
    logic [15:0] ea;
    logic [15:0] eb;
    logic        epa;
    logic        epb;
  } vec_t;

  typedef struct {
    logic [15:0] ea;
    logic [15:0] eb;
    logic        epa;
    logic        epb;
  } exp_t;

  logic        clock = 1'b0;
  logic        reset;
  logic        in_act_write_res_to_reg;
  logic [15:0] in_res;
  logic [3:0]  in_res_reg_idx;
  logic        in_issue_valid;
  logic [3:0]  in_issue_dst_idx;
  logic [3:0]  in_rd_idx_a;
  logic [3:0]  in_rd_idx_b;
  logic [15:0] out_rd_data_a;
  logic [15:0] out_rd_data_b;
  logic        out_pending_a;
  logic        out_pending_b;
  logic        out_stall;

  int   n_cmp = 0;
  int   n_bad = 0;
  exp_t sb[$];
  vec_t tbl[18];

  regfile_wb_sink #(.IALU_WORD_WIDTH(16), .REG_IDX_WIDTH(4)) dut (
    .clock                   (clock),
    .reset                   (reset),
    .in_act_write_res_to_reg (in_act_write_res_to_reg),
    .in_res                  (in_res),
    .in_res_reg_idx          (in_res_reg_idx),
    .in_issue_valid          (in_issue_valid),
    .in_issue_dst_idx        (in_issue_dst_idx),
    .in_rd_idx_a             (in_rd_idx_a),
    .in_rd_idx_b             (in_rd_idx_b),
    .out_rd_data_a           (out_rd_data_a),
    .out_rd_data_b           (out_rd_data_b),
    .out_pending_a           (out_pending_a),
    .out_pending_b           (out_pending_b),
    .out_stall               (out_stall)
  );

  always #5 clock = ~clock;

  function automatic vec_t mk(logic rst, logic wr, logic [15:0] res, logic [3:0] widx,
                              logic iss, logic [3:0] iidx, logic [3:0] ra, logic [3:0] rb,
                              logic chk, logic [15:0] ea, logic [15:0] eb,
                              logic epa, logic epb);
    vec_t v;
    v.rst = rst; v.wr = wr; v.res = res; v.widx = widx;
    v.iss = iss; v.iidx = iidx; v.ra = ra; v.rb = rb;
    v.chk = chk; v.ea = ea; v.eb = eb; v.epa = epa; v.epb = epb;
    return v;
  endfunction

  function automatic vec_t rd(logic [3:0] ra, logic [3:0] rb, logic [15:0] ea,
                              logic [15:0] eb, logic epa, logic epb);
    return mk(1'b0, 1'b0, 16'h0, 4'd0, 1'b0, 4'd0, ra, rb, 1'b1, ea, eb, epa, epb);
  endfunction

  task automatic cmp16(string name, logic [15:0] act, logic [15:0] req);
    n_cmp++;
    if (act !== req) begin
      n_bad++;
      $display("[TB] FAIL %s: got %h, expected %h (t=%0t)", name, act, req, $time);
    end
  endtask

  task automatic cmp1(string name, logic act, logic req);
    n_cmp++;
    if (act !== req) begin
      n_bad++;
      $display("[TB] FAIL %s: got %b, expected %b (t=%0t)", name, act, req, $time);
    end
  endtask

  task automatic checkOutput(string tag);
    exp_t e;
    if (sb.size() == 0) begin
      n_cmp++;
      n_bad++;
      $display("[TB] FAIL %s scoreboard: got empty queue, expected an entry", tag);
      return;
    end
    e = sb.pop_front();
    cmp16({tag, " rd_data_a"}, out_rd_data_a, e.ea);
    cmp16({tag, " rd_data_b"}, out_rd_data_b, e.eb);
    cmp1({tag, " pending_a"}, out_pending_a, e.epa);
    cmp1({tag, " pending_b"}, out_pending_b, e.epb);
    cmp1({tag, " stall"}, out_stall, e.epa | e.epb);
  endtask

  task automatic applyStimulus(vec_t v, string tag);
    exp_t e;
    @(negedge clock);
    reset                   = v.rst;
    in_act_write_res_to_reg = v.wr;
    in_res                  = v.res;
    in_res_reg_idx          = v.widx;
    in_issue_valid          = v.iss;
    in_issue_dst_idx        = v.iidx;
    in_rd_idx_a             = v.ra;
    in_rd_idx_b             = v.rb;
    if (v.chk) begin
      e.ea = v.ea; e.eb = v.eb; e.epa = v.epa; e.epb = v.epb;
      sb.push_back(e);
      #2;
      checkOutput(tag);
    end
  endtask

  task automatic checkAllClear(string tag);
    for (int i = 0; i < 16; i++)
      applyStimulus(rd(4'(i), 4'(15 - i), 16'h0, 16'h0, 1'b0, 1'b0),
                    $sformatf("%s r%0d", tag, i));
  endtask

  initial begin
    reset = 1'b1;
    in_act_write_res_to_reg = 1'b0;
    in_res = '0;
    in_res_reg_idx = '0;
    in_issue_valid = 1'b0;
    in_issue_dst_idx = '0;
    in_rd_idx_a = '0;
    in_rd_idx_b = '0;

    //             rst   wr    res      widx   iss   iidx   ra     rb     chk   exp_a                   exp_b                   pa           pb
    tbl[0]  = mk(1'b0, 1'b1, 16'hBEEF, 4'd3,  1'b0, 4'd0,  4'd3,  4'd9,  1'b1, BYP ? 16'hBEEF : 16'h0, 16'h0,                  1'b0,        1'b0);
    tbl[1]  = mk(1'b0, 1'b1, 16'h1234, 4'd9,  1'b0, 4'd0,  4'd3,  4'd9,  1'b1, 16'hBEEF,               BYP ? 16'h1234 : 16'h0, 1'b0,        1'b0);
    tbl[2]  = rd(4'd3, 4'd9, 16'hBEEF, 16'h1234, 1'b0, 1'b0);
    tbl[3]  = rd(4'd3, 4'd3, 16'hBEEF, 16'hBEEF, 1'b0, 1'b0);
    tbl[4]  = mk(1'b0, 1'b0, 16'h0,    4'd0,  1'b1, 4'd5,  4'd5,  4'd3,  1'b1, 16'h0,                  16'hBEEF,               1'b0,        1'b0);
    tbl[5]  = rd(4'd5, 4'd0, 16'h0, 16'h0, 1'b1, 1'b0);
    tbl[6]  = mk(1'b0, 1'b1, 16'h0042, 4'd5,  1'b0, 4'd0,  4'd5,  4'd5,  1'b1, BYP ? 16'h0042 : 16'h0, BYP ? 16'h0042 : 16'h0, !BYP,        !BYP);
    tbl[7]  = rd(4'd5, 4'd3, 16'h0042, 16'hBEEF, 1'b0, 1'b0);
    tbl[8]  = mk(1'b0, 1'b0, 16'h0,    4'd0,  1'b1, 4'd7,  4'd7,  4'd8,  1'b1, 16'h0,                  16'h0,                  1'b0,        1'b0);
    tbl[9]  = mk(1'b0, 1'b1, 16'h00AA, 4'd7,  1'b1, 4'd7,  4'd7,  4'd8,  1'b1, BYP ? 16'h00AA : 16'h0, 16'h0,                  1'b1,        1'b0);
    tbl[10] = mk(1'b0, 1'b1, 16'h00BB, 4'd7,  1'b1, 4'd8,  4'd7,  4'd8,  1'b1, BYP ? 16'h00BB : 16'h00AA, 16'h0,               !BYP,        1'b0);
    tbl[11] = rd(4'd7, 4'd8, 16'h00BB, 16'h0, 1'b0, 1'b1);
    tbl[12] = mk(1'b0, 1'b0, 16'h0,    4'd0,  1'b1, 4'd2,  4'd2,  4'd8,  1'b1, 16'h0,                  16'h0,                  1'b0,        1'b1);
    tbl[13] = mk(1'b0, 1'b1, 16'h5A5A, 4'd2,  1'b0, 4'd0,  4'd2,  4'd8,  1'b1, BYP ? 16'h5A5A : 16'h0, 16'h0,                  !BYP,        1'b1);
    tbl[14] = rd(4'd2, 4'd2, 16'h5A5A, 16'h5A5A, 1'b0, 1'b0);
    tbl[15] = mk(1'b0, 1'b1, 16'h8001, 4'd15, 1'b0, 4'd0,  4'd15, 4'd0,  1'b1, BYP ? 16'h8001 : 16'h0, 16'h0,                  1'b0,        1'b0);
    tbl[16] = mk(1'b0, 1'b1, 16'h7FFE, 4'd0,  1'b0, 4'd0,  4'd0,  4'd15, 1'b1, BYP ? 16'h7FFE : 16'h0, 16'h8001,               1'b0,        1'b0);
    tbl[17] = rd(4'd0, 4'd15, 16'h7FFE, 16'h8001, 1'b0, 1'b0);

    // Power-on reset for two cycles with stray write/issue that must be ignored.
    applyStimulus(mk(1'b1, 1'b1, 16'hDEAD, 4'd3, 1'b1, 4'd3, 4'd0, 4'd0, 1'b0, 16'h0, 16'h0, 1'b0, 1'b0), "rst0");
    applyStimulus(mk(1'b1, 1'b0, 16'h0, 4'd0, 1'b0, 4'd0, 4'd0, 4'd0, 1'b0, 16'h0, 16'h0, 1'b0, 1'b0), "rst1");
    checkAllClear("reset");

    for (int i = 0; i < 18; i++)
      applyStimulus(tbl[i], $sformatf("vec%0d", i));

    // Mid-operation reset: r1 and r4 pending, r4 = FFFF, then reset with traffic.
    applyStimulus(mk(1'b0, 1'b0, 16'h0, 4'd0, 1'b1, 4'd1, 4'd1, 4'd4, 1'b0, 16'h0, 16'h0, 1'b0, 1'b0), "mid_iss1");
    applyStimulus(mk(1'b0, 1'b0, 16'h0, 4'd0, 1'b1, 4'd4, 4'd1, 4'd4, 1'b0, 16'h0, 16'h0, 1'b0, 1'b0), "mid_iss4");
    applyStimulus(mk(1'b0, 1'b1, 16'hFFFF, 4'd4, 1'b1, 4'd4, 4'd1, 4'd6, 1'b0, 16'h0, 16'h0, 1'b0, 1'b0), "mid_wr4");
    applyStimulus(rd(4'd1, 4'd4, 16'h0, 16'hFFFF, 1'b1, 1'b1), "mid_pre");
    applyStimulus(mk(1'b1, 1'b1, 16'h1111, 4'd1, 1'b1, 4'd6, 4'd1, 4'd6, 1'b0, 16'h0, 16'h0, 1'b0, 1'b0), "mid_rst");
    checkAllClear("midreset");
    applyStimulus(rd(4'd6, 4'd4, 16'h0, 16'h0, 1'b0, 1'b0), "mid_r6");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #20000;
    $display("[TB] FAIL timeout: got no completion, expected finish before 20000");
    $fatal(1, "[TB] timeout");
  end

endmodule
